// File: rtl/ssd1306_spi_rx_pkg.sv
// Shared opcodes, FSM state and addressing-mode types for the SSD1306 SPI responder.
// SSD1306_RX_VADDR_EN adds the MODE state (memory addressing mode argument).
package ssd1306_pkg;

  localparam logic [7:0] CMD_SET_COL     = 8'h21;
  localparam logic [7:0] CMD_SET_PAGE    = 8'h22;
  localparam logic [7:0] CMD_DISP_OFF    = 8'hAE;
  localparam logic [7:0] CMD_DISP_ON     = 8'hAF;
  localparam logic [7:0] CMD_MEM_MODE    = 8'h20;

  localparam logic [7:0] CMD_CONTRAST    = 8'h81;
  localparam logic [7:0] CMD_CHARGE_PUMP = 8'h8D;
  localparam logic [7:0] CMD_MUX_RATIO   = 8'hA8;
  localparam logic [7:0] CMD_DISP_OFFSET = 8'hD3;
  localparam logic [7:0] CMD_CLK_DIV     = 8'hD5;
  localparam logic [7:0] CMD_PRECHARGE   = 8'hD9;
  localparam logic [7:0] CMD_COM_PINS    = 8'hDA;
  localparam logic [7:0] CMD_VCOMH       = 8'hDB;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COL_LO  = 3'd1,
    ST_COL_HI  = 3'd2,
    ST_PAGE_LO = 3'd3,
    ST_PAGE_HI = 3'd4,
`ifdef SSD1306_RX_VADDR_EN
    ST_SKIP1   = 3'd5,
    ST_MODE    = 3'd6
`else
    ST_SKIP1   = 3'd5
`endif
  } cmd_state_t;

  typedef enum logic {
    MODE_HORIZ = 1'b0,
    MODE_VERT  = 1'b1
  } addr_mode_t;

  // Opcodes whose single argument byte is swallowed without effect.
  function automatic logic is_one_arg(input logic [7:0] op);
    case (op)
      CMD_CONTRAST, CMD_CHARGE_PUMP, CMD_MUX_RATIO, CMD_DISP_OFFSET,
      CMD_CLK_DIV, CMD_PRECHARGE, CMD_COM_PINS, CMD_VCOMH: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ssd1306_spi_rx_if.sv
// Pin bundle of the SSD1306 4-wire SPI link (plus RES#) as seen on the PMOD header.
// The initiator drives every pin (master); the responder only observes (slave).
interface ssd1306_spi_rx_if;
  logic i_SPI_Clk;
  logic i_SPI_MOSI;
  logic i_SPI_CS_n;
  logic i_DC;
  logic i_RES_n;

  modport master (
    output i_SPI_Clk, i_SPI_MOSI, i_SPI_CS_n, i_DC, i_RES_n
  );

  modport slave (
    input i_SPI_Clk, i_SPI_MOSI, i_SPI_CS_n, i_DC, i_RES_n
  );
endinterface

// File: rtl/ssd1306_spi_rx_byte_rx.sv
// Synchronizes the SPI pins, detects SCLK rising edges and assembles MSB-first bytes.
// rx_valid is a one-cycle strobe with no ready: the consumer must take rx_byte/rx_dc that cycle.
module spi_byte_rx (
  input  logic                  clk,
  input  logic                  rst_n,
  ssd1306_spi_rx_if.slave       spi,
  output logic [7:0]            rx_byte,
  output logic                  rx_dc,
  output logic                  rx_valid,
  output logic                  res_n_sync
);

  logic [1:0] sclk_s;
  logic [1:0] mosi_s;
  logic [1:0] cs_s;
  logic [1:0] dc_s;
  logic [1:0] res_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s <= 2'b00;
      mosi_s <= 2'b00;
      cs_s   <= 2'b11;
      dc_s   <= 2'b00;
      res_s  <= 2'b00;
    end else begin
      sclk_s <= {sclk_s[0], spi.i_SPI_Clk};
      mosi_s <= {mosi_s[0], spi.i_SPI_MOSI};
      cs_s   <= {cs_s[0],   spi.i_SPI_CS_n};
      dc_s   <= {dc_s[0],   spi.i_DC};
      res_s  <= {res_s[0],  spi.i_RES_n};
    end
  end

  assign res_n_sync = res_s[1];

  logic       sclk_d;
  logic       rise_q;
  logic       mosi_q;
  logic       dc_q;
  logic [2:0] bit_cnt;
  logic [6:0] shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_d   <= 1'b0;
      rise_q   <= 1'b0;
      mosi_q   <= 1'b0;
      dc_q     <= 1'b0;
      bit_cnt  <= 3'd0;
      shift    <= 7'd0;
      rx_byte  <= 8'd0;
      rx_dc    <= 1'b0;
      rx_valid <= 1'b0;
    end else if (!res_s[1]) begin
      // Keep tracking SCLK so releasing RES# with SCLK high is not seen as an edge.
      sclk_d   <= sclk_s[1];
      rise_q   <= 1'b0;
      mosi_q   <= 1'b0;
      dc_q     <= 1'b0;
      bit_cnt  <= 3'd0;
      shift    <= 7'd0;
      rx_byte  <= 8'd0;
      rx_dc    <= 1'b0;
      rx_valid <= 1'b0;
    end else begin
      sclk_d   <= sclk_s[1];
      rise_q   <= sclk_s[1] & ~sclk_d & ~cs_s[1];
      mosi_q   <= mosi_s[1];
      dc_q     <= dc_s[1];
      rx_valid <= 1'b0;
      if (cs_s[1]) begin
        bit_cnt <= 3'd0;
      end else if (rise_q) begin
        shift   <= {shift[5:0], mosi_q};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          rx_byte  <= {shift, mosi_q};
          rx_dc    <= dc_q;
          rx_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ssd1306_spi_rx.sv
// SSD1306 SPI responder: command FSM, column/page window and framebuffer write pointer.
// SSD1306_RX_VADDR_EN enables the 0x20 addressing-mode argument and vertical addressing.
module ssd1306_spi_rx
  import ssd1306_pkg::*;
#(
  parameter int COLS = 128,
  parameter int PAGES = 8,
  localparam int AW = $clog2(COLS * PAGES)
) (
  input  logic                i_Clk,
  input  logic                i_Rst_L,
  ssd1306_spi_rx_if.slave     spi,
  output logic                o_Wr_En,
  output logic [AW-1:0]       o_Wr_Addr,
  output logic [7:0]          o_Wr_Data,
  output logic                o_Cmd_Valid,
  output logic [7:0]          o_Cmd_Byte,
  output logic                o_Display_On,
  output logic                o_Frame_Done,
  output logic [2:0]          o_Fsm_State
);

  localparam int CW = (COLS  > 1) ? $clog2(COLS)  : 1;
  localparam int PW = (PAGES > 1) ? $clog2(PAGES) : 1;
  localparam logic [7:0]    COL_MAX8  = 8'(COLS - 1);
  localparam logic [7:0]    PAGE_MAX8 = 8'(PAGES - 1);
  localparam logic [CW-1:0] COL_MAX   = CW'(COLS - 1);
  localparam logic [PW-1:0] PAGE_MAX  = PW'(PAGES - 1);

  // Async assert, synchronous release.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  logic [7:0] rx_byte;
  logic       rx_dc;
  logic       rx_valid;
  logic       res_n_sync;

  spi_byte_rx u_byte_rx (
    .clk        (i_Clk),
    .rst_n      (rst_n),
    .spi        (spi),
    .rx_byte    (rx_byte),
    .rx_dc      (rx_dc),
    .rx_valid   (rx_valid),
    .res_n_sync (res_n_sync)
  );

  function automatic logic [CW-1:0] clamp_col(input logic [7:0] v);
    if (v > COL_MAX8) return COL_MAX;
    else              return v[CW-1:0];
  endfunction

  function automatic logic [PW-1:0] clamp_page(input logic [7:0] v);
    if (v > PAGE_MAX8) return PAGE_MAX;
    else               return v[PW-1:0];
  endfunction

  cmd_state_t    state;
  addr_mode_t    mode;
  logic [CW-1:0] col, col_start, col_end, pend_col, arg_col;
  logic [PW-1:0] page, page_start, page_end, pend_page, arg_page;
  logic [CW-1:0] nxt_col;
  logic [PW-1:0] nxt_page;
  logic          wrap;

  assign arg_col  = clamp_col(rx_byte);
  assign arg_page = clamp_page(rx_byte);
  assign o_Fsm_State = state;

`ifdef SSD1306_RX_VADDR_EN
  addr_mode_t mode_q;
  assign mode = mode_q;
`else
  assign mode = MODE_HORIZ;
`endif

  // Pointer step after a write; wrap flags the end of the whole window.
  always_comb begin
    nxt_col  = col;
    nxt_page = page;
    wrap     = 1'b0;
    if (mode == MODE_VERT) begin
      if (page == page_end) begin
        nxt_page = page_start;
        if (col == col_end) begin
          nxt_col = col_start;
          wrap    = 1'b1;
        end else begin
          nxt_col = col + 1'b1;
        end
      end else begin
        nxt_page = page + 1'b1;
      end
    end else begin
      if (col == col_end) begin
        nxt_col = col_start;
        if (page == page_end) begin
          nxt_page = page_start;
          wrap     = 1'b1;
        end else begin
          nxt_page = page + 1'b1;
        end
      end else begin
        nxt_col = col + 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      col          <= '0;
      col_start    <= '0;
      col_end      <= COL_MAX;
      pend_col     <= '0;
      page         <= '0;
      page_start   <= '0;
      page_end     <= PAGE_MAX;
      pend_page    <= '0;
      o_Wr_En      <= 1'b0;
      o_Wr_Addr    <= '0;
      o_Wr_Data    <= 8'd0;
      o_Cmd_Valid  <= 1'b0;
      o_Cmd_Byte   <= 8'd0;
      o_Display_On <= 1'b0;
      o_Frame_Done <= 1'b0;
`ifdef SSD1306_RX_VADDR_EN
      mode_q       <= MODE_HORIZ;
`endif
    end else if (!res_n_sync) begin
      state        <= ST_IDLE;
      col          <= '0;
      col_start    <= '0;
      col_end      <= COL_MAX;
      pend_col     <= '0;
      page         <= '0;
      page_start   <= '0;
      page_end     <= PAGE_MAX;
      pend_page    <= '0;
      o_Wr_En      <= 1'b0;
      o_Wr_Addr    <= '0;
      o_Wr_Data    <= 8'd0;
      o_Cmd_Valid  <= 1'b0;
      o_Cmd_Byte   <= 8'd0;
      o_Display_On <= 1'b0;
      o_Frame_Done <= 1'b0;
`ifdef SSD1306_RX_VADDR_EN
      mode_q       <= MODE_HORIZ;
`endif
    end else begin
      o_Wr_En      <= 1'b0;
      o_Cmd_Valid  <= 1'b0;
      o_Frame_Done <= 1'b0;
      if (rx_valid) begin
        if (rx_dc) begin
          // A data byte always writes, abandoning any half-received command.
          state        <= ST_IDLE;
          o_Wr_En      <= 1'b1;
          o_Wr_Addr    <= AW'(int'(page) * COLS + int'(col));
          o_Wr_Data    <= rx_byte;
          o_Frame_Done <= wrap;
          col          <= nxt_col;
          page         <= nxt_page;
        end else begin
          case (state)
            ST_IDLE: begin
              o_Cmd_Valid <= 1'b1;
              o_Cmd_Byte  <= rx_byte;
              if (rx_byte == CMD_SET_COL)        state <= ST_COL_LO;
              else if (rx_byte == CMD_SET_PAGE)  state <= ST_PAGE_LO;
`ifdef SSD1306_RX_VADDR_EN
              else if (rx_byte == CMD_MEM_MODE)  state <= ST_MODE;
`else
              else if (rx_byte == CMD_MEM_MODE)  state <= ST_SKIP1;
`endif
              else if (is_one_arg(rx_byte))      state <= ST_SKIP1;
              else if (rx_byte == CMD_DISP_ON)   o_Display_On <= 1'b1;
              else if (rx_byte == CMD_DISP_OFF)  o_Display_On <= 1'b0;
            end
            ST_COL_LO: begin
              pend_col <= arg_col;
              state    <= ST_COL_HI;
            end
            ST_COL_HI: begin
              col_start <= pend_col;
              col_end   <= (arg_col < pend_col) ? pend_col : arg_col;
              col       <= pend_col;
              state     <= ST_IDLE;
            end
            ST_PAGE_LO: begin
              pend_page <= arg_page;
              state     <= ST_PAGE_HI;
            end
            ST_PAGE_HI: begin
              page_start <= pend_page;
              page_end   <= (arg_page < pend_page) ? pend_page : arg_page;
              page       <= pend_page;
              state      <= ST_IDLE;
            end
`ifdef SSD1306_RX_VADDR_EN
            ST_MODE: begin
              mode_q <= (rx_byte[1:0] == 2'b01) ? MODE_VERT : MODE_HORIZ;
              state  <= ST_IDLE;
            end
`endif
            default: state <= ST_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ssd1306_spi_rx.sv
// Directed bench for ssd1306_spi_rx: drives SPI bytes and checks writes, commands and flags.
// Vertical-addressing expectations follow SSD1306_RX_VADDR_EN.
module tb_ssd1306_spi_rx;

  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst_l;
  always #5 clk = ~clk;

  ssd1306_spi_rx_if spi_if ();

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          cmd_valid;
  logic [7:0]    cmd_byte;
  logic          disp_on;
  logic          frame_done;
  logic [2:0]    fsm_state;

  ssd1306_spi_rx #(.COLS(128), .PAGES(8)) dut (
    .i_Clk        (clk),
    .i_Rst_L      (rst_l),
    .spi          (spi_if),
    .o_Wr_En      (wr_en),
    .o_Wr_Addr    (wr_addr),
    .o_Wr_Data    (wr_data),
    .o_Cmd_Valid  (cmd_valid),
    .o_Cmd_Byte   (cmd_byte),
    .o_Display_On (disp_on),
    .o_Frame_Done (frame_done),
    .o_Fsm_State  (fsm_state)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_rise = 0;

  logic [18:0] wr_q[$];
  logic [18:0] exp_q[$];
  logic [7:0]  cmd_q[$];
  int          lat_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: records every strobe as {frame_done, addr, data} / opcode plus its latency.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wr_q.push_back({frame_done, wr_addr, wr_data});
      lat_q.push_back(cyc - last_rise);
    end
    if (cmd_valid === 1'b1) begin
      cmd_q.push_back(cmd_byte);
      lat_q.push_back(cyc - last_rise);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic fd, input int addr, input logic [7:0] data);
    exp_q.push_back({fd, AW'(addr), data});
  endtask

  task automatic check_writes(input string tag);
    logic [18:0] e;
    check({tag, "_count"}, 32'(wr_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (wr_q.size() > 0) check(tag, 32'(wr_q.pop_front()), 32'(e));
    end
    wr_q.delete();
  endtask

  task automatic check_latency(input string tag);
    int l;
    while (lat_q.size() > 0) begin
      l = lat_q.pop_front();
      check(tag, 32'(l), 32'd4);
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input logic dc, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      @(negedge clk);
      spi_if.i_SPI_MOSI = b[i];
      spi_if.i_DC       = dc;
      repeat (4) @(negedge clk);
      spi_if.i_SPI_Clk = 1'b1;
      last_rise = cyc + 1;
      repeat (4) @(negedge clk);
      spi_if.i_SPI_Clk = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic dc);
    send_bits(b, dc, 8);
    repeat (4) @(negedge clk);
  endtask

  task automatic cmd(input logic [7:0] b);
    send_byte(b, 1'b0);
  endtask

  task automatic data(input logic [7:0] b);
    send_byte(b, 1'b1);
  endtask

  task automatic settle();
    repeat (10) @(negedge clk);
  endtask

  task automatic res_pulse();
    @(negedge clk);
    spi_if.i_RES_n = 1'b0;
    repeat (6) @(negedge clk);
    spi_if.i_RES_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    rst_l             = 1'b0;
    spi_if.i_SPI_Clk  = 1'b0;
    spi_if.i_SPI_MOSI = 1'b0;
    spi_if.i_SPI_CS_n = 1'b1;
    spi_if.i_DC       = 1'b0;
    spi_if.i_RES_n    = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_wr_en",   32'(wr_en),      32'd0);
    check("rst_cmd_vld", 32'(cmd_valid),  32'd0);
    check("rst_disp_on", 32'(disp_on),    32'd0);
    check("rst_frame",   32'(frame_done), 32'd0);
    check("rst_addr",    32'(wr_addr),    32'd0);
    check("rst_data",    32'(wr_data),    32'd0);
    check("rst_cmd",     32'(cmd_byte),   32'd0);
    check("rst_state",   32'(fsm_state),  32'd0);
    rst_l = 1'b1;
    repeat (10) @(negedge clk);
    spi_if.i_SPI_CS_n = 1'b0;
    repeat (4) @(negedge clk);

    // Three data bytes after reset land at 0,1,2
    data(8'hA5); data(8'hA5); data(8'hA5);
    settle();
    push_exp(1'b0, 0, 8'hA5); push_exp(1'b0, 1, 8'hA5); push_exp(1'b0, 2, 8'hA5);
    check_writes("t1_wr");
    check("t1_disp_on", 32'(disp_on), 32'd0);
    check("t1_no_cmd", 32'(cmd_q.size()), 32'd0);
    check_latency("t1_latency");

    // Window col 16..18, page 1..2
    res_pulse();
    cmd(8'h21); cmd(8'h10); cmd(8'h12);
    cmd(8'h22); cmd(8'h01); cmd(8'h02);
    for (int i = 0; i < 6; i++) data(8'(8'h11 + i));
    settle();
    push_exp(1'b0, 144, 8'h11); push_exp(1'b0, 145, 8'h12); push_exp(1'b0, 146, 8'h13);
    push_exp(1'b0, 272, 8'h14); push_exp(1'b0, 273, 8'h15); push_exp(1'b1, 274, 8'h16);
    check_writes("t2_wr");
    check("t2_cmd_cnt", 32'(cmd_q.size()), 32'd2);
    if (cmd_q.size() == 2) begin
      check("t2_cmd0", 32'(cmd_q[0]), 32'h21);
      check("t2_cmd1", 32'(cmd_q[1]), 32'h22);
    end
    cmd_q.delete();

    // Display on, then 0xAF swallowed as the contrast argument
    cmd(8'hAF); cmd(8'h81); cmd(8'hAF);
    settle();
    check("t3_disp_on", 32'(disp_on), 32'd1);
    check("t3_cmd_cnt", 32'(cmd_q.size()), 32'd2);
    if (cmd_q.size() == 2) begin
      check("t3_cmd0", 32'(cmd_q[0]), 32'hAF);
      check("t3_cmd1", 32'(cmd_q[1]), 32'h81);
    end
    check("t3_state", 32'(fsm_state), 32'd0);
    cmd_q.delete();
    cmd(8'hAE);
    settle();
    check("t3_disp_off", 32'(disp_on), 32'd0);
    cmd_q.delete();

    // Partial byte discarded by CS_n high
    res_pulse();
    send_bits(8'hFF, 1'b1, 5);
    @(negedge clk);
    spi_if.i_SPI_CS_n = 1'b1;
    repeat (6) @(negedge clk);
    spi_if.i_SPI_CS_n = 1'b0;
    repeat (4) @(negedge clk);
    data(8'h3C);
    settle();
    push_exp(1'b0, 0, 8'h3C);
    check_writes("t4_wr");

    // Aborted column command, then clamping of out-of-range arguments
    res_pulse();
    cmd(8'h21);
    settle();
    check("t5_state_col_lo", 32'(fsm_state), 32'd1);
    cmd(8'h90);
    data(8'h55);
    settle();
    check("t5_state_idle", 32'(fsm_state), 32'd0);
    data(8'h66);
    cmd(8'h21); cmd(8'h90); cmd(8'h05);
    cmd(8'h22); cmd(8'h0A); cmd(8'h00);
    data(8'h77); data(8'h88);
    settle();
    push_exp(1'b0, 0, 8'h55); push_exp(1'b0, 1, 8'h66);
    push_exp(1'b1, 1023, 8'h77); push_exp(1'b1, 1023, 8'h88);
    check_writes("t5_wr");
    check("t5_cmd_cnt", 32'(cmd_q.size()), 32'd3);
    if (cmd_q.size() == 3) check("t5_cmd0", 32'(cmd_q[0]), 32'h21);
    cmd_q.delete();

    // RES# mid-window at (page 3, col 5)
    res_pulse();
    cmd(8'hAF);
    cmd(8'h21); cmd(8'h05); cmd(8'h7F);
    cmd(8'h22); cmd(8'h03); cmd(8'h07);
    data(8'h99);
    settle();
    check("t6_disp_on", 32'(disp_on), 32'd1);
    res_pulse();
    check("t6_disp_after_res", 32'(disp_on), 32'd0);
    check("t6_state_after_res", 32'(fsm_state), 32'd0);
    data(8'h42);
    settle();
    push_exp(1'b0, 389, 8'h99); push_exp(1'b0, 0, 8'h42);
    check_writes("t6_wr");
    cmd_q.delete();

    // 0x20,0x01 then 9 bytes in the default window
    res_pulse();
    cmd(8'h20); cmd(8'h01);
    for (int i = 0; i < 9; i++) data(8'(8'h30 + i));
    settle();
    for (int i = 0; i < 9; i++) begin
`ifdef SSD1306_RX_VADDR_EN
      push_exp(1'b0, (i < 8) ? i * 128 : 1, 8'(8'h30 + i));
`else
      push_exp(1'b0, i, 8'(8'h30 + i));
`endif
    end
    check_writes("t7_wr");
    check("t7_cmd_cnt", 32'(cmd_q.size()), 32'd1);
    if (cmd_q.size() == 1) check("t7_cmd0", 32'(cmd_q[0]), 32'h20);
    cmd_q.delete();

    check_latency("latency");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ssd1306_spi_rx.md
# ssd1306_spi_rx

SPI responder for the SSD1306 display link: decodes the 4-wire write-only stream (SCLK, MOSI, CS#, D/C#, RES#) that our SSD1306 initiator drives on the PMOD header. It tracks the SSD1306 column/page address window and emits one framebuffer write per data byte. It also reports command opcodes and display on/off state. It serves as the display model in loopback benches and as the front end of an on-FPGA display emulator.

## Interface
- COLS, 128, columns per page (≤128)
- PAGES, 8, pages (8 rows each) (≤8)
- i_Clk  in  1  system clock; ≥6× SCLK frequency
- i_Rst_L  in  1  asynchronous active-low reset
- i_SPI_Clk  in  1  SCLK (D0), asynchronous
- i_SPI_MOSI  in  1  MOSI (D1), asynchronous
- i_SPI_CS_n  in  1  chip select, active-low, asynchronous
- i_DC  in  1  0 = command byte, 1 = data byte, asynchronous
- i_RES_n  in  1  display reset pin, active-low, asynchronous
- o_Wr_En  out  1  one-cycle framebuffer write strobe
- o_Wr_Addr  out  $clog2(COLS*PAGES)  page*COLS + col
- o_Wr_Data  out  8  data byte (bit0 = top row of page)
- o_Cmd_Valid  out  1  one-cycle strobe per opcode byte (not argument bytes)
- o_Cmd_Byte  out  8  opcode
- o_Display_On  out  1  set by 0xAF, cleared by 0xAE
- o_Frame_Done  out  1  one-cycle strobe when the write pointer wraps the window

## Operation
- All five pins pass through 2-flop synchronizers. SPI mode 0, MSB first. MOSI is sampled on the synchronized SCLK rising edge.
- Bit counter 0..7. CS_n high clears the counter and discards any partial byte. SCLK edges while CS_n is high are ignored.
- D/C is sampled with bit 7 (the LSB).
- Command FSM states: IDLE, COL_LO, COL_HI, PAGE_LO, PAGE_HI, SKIP1, MODE (MODE exists only with the macro).
  - 0x21 goes IDLE→COL_LO→COL_HI→IDLE. It loads col_start/col_end and sets col=col_start.
  - 0x22 goes IDLE→PAGE_LO→PAGE_HI→IDLE. It loads page_start/page_end and sets page=page_start.
  - 0xAE/0xAF update o_Display_On.
  - 0x81, 0x8D, 0xA8, 0xD3, 0xD5, 0xD9, 0xDA, 0xDB each consume one argument via SKIP1.
  - 0x20 consumes one argument (MODE or SKIP1, per Configuration).
  - All other opcodes are single-byte.
  - Every opcode received in IDLE pulses o_Cmd_Valid. Argument bytes do not.
- Argument rules:
  - Column values are clamped to COLS-1; page values are clamped to PAGES-1.
  - If end < start, end is set to start.
- A data byte received in any non-IDLE state aborts the pending sequence: FSM returns to IDLE and the byte is written normally.
- Horizontal addressing on each data byte:
  - Write at (page, col).
  - If col==col_end: col←col_start and page advances.
  - If page was page_end: page←page_start and o_Frame_Done pulses together with o_Wr_En.
- Synchronized i_RES_n low acts as a synchronous soft reset to the reset state below, held while low.
- Reset values:
  - All outputs are 0.
  - FSM is IDLE; bit counter is 0.
  - Window is col 0..COLS-1, page 0..PAGES-1; pointer is (0,0).
  - Mode is horizontal.

## Timing
- Pipeline stages: sync (2 cycles), edge detect/shift (1 cycle), registered outputs (1 cycle).
- o_Wr_En / o_Cmd_Valid assert exactly 4 i_Clk cycles after the first i_Clk edge that samples SCLK's 8th rising edge high. They stay high for 1 cycle.
- o_Wr_Addr/o_Wr_Data are valid only while o_Wr_En is high.
- SCLK high and low phases must each be ≥3 i_Clk periods.
- MOSI and D/C must be stable for ≥3 i_Clk periods around the SCLK rising edge.
- Minimum byte spacing is therefore 48 i_Clk cycles. No internal back-pressure; no byte is ever dropped at legal rates.
- CS_n falling edge to first SCLK rising edge must be ≥3 cycles.
- Asynchronous i_Rst_L takes effect immediately. Deassertion is released through the reset synchronizer.

## Configuration
- SSD1306_RX_VADDR_EN defined:
  - 0x20 enters MODE. Arg[1:0]=01 selects vertical mode; other values select horizontal.
  - In vertical mode, page increments first; at page_end, page←page_start and col advances; wrap at col_end pulses o_Frame_Done.
- Undefined: 0x20 uses SKIP1, and addressing is always horizontal.

## Structure
- Package ssd1306_pkg holds:
  - opcode localparams (CMD_SET_COL=0x21, CMD_SET_PAGE=0x22, CMD_DISP_OFF=0xAE, CMD_DISP_ON=0xAF, CMD_MEM_MODE=0x20, one-argument opcode list)
  - FSM state enum typedef
  - addressing-mode typedef
- Sub-module spi_byte_rx contains the synchronizers, SCLK edge detect, bit counter, and shift register. It outputs byte, dc, and a byte-strobe.
- The top level holds the command FSM and the address pointers.

## Test plan
- Reset then data 0xA5 ×3 → writes addr 0,1,2 with data 0xA5; o_Display_On=0.
- 0x21,0x10,0x12 then 0x22,0x01,0x02, then 6 data bytes → addrs 144,145,146,272,273,274; o_Frame_Done pulses on the 6th byte only.
- 0xAF, then 0x81,0xAF → o_Display_On=1; exactly 2 o_Cmd_Valid pulses (0xAF, 0x81); the second 0xAF is consumed as an argument.
- CS_n deasserted after 5 bits, then a full byte 0x3C with DC=1 → single write of 0x3C; the partial byte is discarded.
- 0x21,0x90 then a data byte 0x55 → FSM aborts; write at addr 0 (pointer unchanged); col_start stays 0.
- i_RES_n pulsed low mid-window at pointer (3,5) → the next data byte writes addr 0. Vertical mode (macro defined) via 0x20,0x01: 9 bytes in the default window → addrs 0,128,…,896, then 1.
